// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// Module  : fifo_sync_param
// Brief   : Single-clock parametrised FIFO with threshold flags, occupancy
//           count, error pulses and selectable registered / FWFT read port.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_sync_param #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              c_depth     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] c_depth_cnt = (ADDR_W + 1)'(c_depth);
  localparam logic [ADDR_W:0] c_afull     = (ADDR_W + 1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0] c_aempty    = (ADDR_W + 1)'(AEMPTY_THRESH);

  logic [DATA_W-1:0] r_mem [c_depth];

  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] r_count;
  logic            r_full;
  logic            r_empty;
  logic            r_almost_full;
  logic            r_almost_empty;
  logic            r_overflow;
  logic            r_underflow;

  logic            w_wr_acc;
  logic            w_rd_acc;
  logic [ADDR_W:0] w_count_next;

  // Full rejects the write and empty rejects the read, which yields the
  // required priority when both requests arrive at a boundary.
  assign w_wr_acc     = wr_en && !r_full;
  assign w_rd_acc     = rd_en && !r_empty;
  assign w_count_next = r_count + (ADDR_W + 1)'(w_wr_acc) - (ADDR_W + 1)'(w_rd_acc);

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count        <= w_count_next;
      r_full         <= (w_count_next == c_depth_cnt);
      r_empty        <= (w_count_next == '0);
      r_almost_full  <= (w_count_next >= c_afull);
      r_almost_empty <= (w_count_next <= c_aempty);
      r_overflow     <= wr_en && r_full;
      r_underflow    <= rd_en && r_empty;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_W-1:0] r_rd_data;
      logic              r_rd_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
          end
        end
      end

      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
    end else begin : g_fwft_read
      // Head word is presented combinationally; rd_en only advances the pointer.
      assign rd_data  = r_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
      assign rd_valid = !r_empty;
    end
  endgenerate

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
// ---------------------------------------------------------------------------
// Module  : tb_fifo_sync_param
// Brief   : Bench for fifo_sync_param, registered and FWFT instances driven
//           by shared stimulus and checked against a queue model.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fifo_sync_param;

  localparam int c_depth = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;

  logic [7:0] rd_data, rd_data_f;
  logic       rd_valid, rd_valid_f;
  logic       full, full_f, empty, empty_f;
  logic       almost_full, almost_full_f, almost_empty, almost_empty_f;
  logic [4:0] count, count_f;
  logic       overflow, overflow_f, underflow, underflow_f;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_rd_data = 8'h00;
  bit         m_rd_valid = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(0)) u_dut_reg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(1)) u_dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_f), .rd_valid(rd_valid_f), .full(full_f), .empty(empty_f),
    .almost_full(almost_full_f), .almost_empty(almost_empty_f), .count(count_f),
    .overflow(overflow_f), .underflow(underflow_f)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check_eq("count",        32'(count),        32'(n));
    check_eq("full",         32'(full),         32'(n == c_depth));
    check_eq("empty",        32'(empty),        32'(n == 0));
    check_eq("almost_full",  32'(almost_full),  32'(n >= 12));
    check_eq("almost_empty", 32'(almost_empty), 32'(n <= 2));
    check_eq("overflow",     32'(overflow),     32'(m_ovf));
    check_eq("underflow",    32'(underflow),    32'(m_unf));
    check_eq("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
    check_eq("rd_data",      32'(rd_data),      32'(m_rd_data));
    check_eq("f_count",      32'(count_f),      32'(n));
    check_eq("f_ovf_unf",    32'({overflow_f, underflow_f}), 32'({m_ovf, m_unf}));
    check_eq("f_rd_valid",   32'(rd_valid_f),   32'(n != 0));
    check_eq("f_rd_data",    32'(rd_data_f),    (n != 0) ? 32'(q[0]) : 32'h0);
  endtask

  // One clock: drive at negedge, advance the model, check just after the edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r);
    int pre;
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    pre = q.size();
    m_ovf = w && (pre == c_depth);
    m_unf = r && (pre == 0);
    m_rd_valid = 1'b0;
    if (r && pre > 0) begin
      m_rd_data  = q.pop_front();
      m_rd_valid = 1'b1;
    end
    if (w && pre < c_depth) q.push_back(d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_rd_data  = 8'h00;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();

    // Fill then overflow
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Drain then underflow; rd_data must hold 0x0F
    for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1);
    check_eq("hold_last", 32'(rd_data), 32'h0F);

    // Simultaneous at count 8, then at full, then at empty
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h99, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Wrap: interleaved writes/reads pushing pointers past 31
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'b0);
      step(1'b0, 8'h00, 1'b1);
    end

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50));
    end
    while (q.size() != 0) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // FWFT fall-through of a single word, then pop
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check_eq("fwft_a5", 32'(rd_data_f), 32'hA5);
    step(1'b0, 8'h00, 1'b1);
    check_eq("fwft_pop", 32'({empty_f, rd_data_f}), 32'h100);

    // Asynchronous reset mid-stream at count 9
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_eq("post_rst_data", 32'(rd_data), 32'h3C);
    step(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
